// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle control unit: FSM states, instruction
// classes, ALU operations, condition codes and datapath select values.
package multicycle_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BRANCH,
        S_EXUSTART,
        S_EXUWAIT,
        S_EXUWB,
        S_FAULT
    } state_t;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;
    localparam logic [1:0] OP_EXU = 2'b11;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_ORR = 3'b011;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;

    localparam logic [1:0] SRCA_PC   = 2'b01;
    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;
    localparam logic [1:0] RES_RDATA = 2'b01;
    localparam logic [1:0] RES_ALU   = 2'b10;

    // Unlisted data-processing commands fall back to ADD.
    function automatic logic [2:0] alu_decode(input logic [3:0] cmd);
        case (cmd)
            CMD_ADD: return ALU_ADD;
            CMD_SUB: return ALU_SUB;
            CMD_AND: return ALU_AND;
            CMD_ORR: return ALU_ORR;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/mc_condunit.sv
// Condition unit: holds the NZCV flags register, evaluates CondEx for the
// current instruction and applies gated flag writes.
module mc_condunit
    import multicycle_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] Cond,
    input  logic [3:0] ALUFlags,
    input  logic [1:0] FlagW,
    input  logic       FlagUpd,
    output logic       CondEx
);

    logic [3:0] flags;
    logic       n, z, c, v;

    assign {n, z, c, v} = flags;

    always_comb begin
        CondEx = 1'b0;
        case (Cond)
            COND_EQ: CondEx = z;
            COND_NE: CondEx = ~z;
            COND_CS: CondEx = c;
            COND_CC: CondEx = ~c;
            COND_MI: CondEx = n;
            COND_PL: CondEx = ~n;
            COND_VS: CondEx = v;
            COND_VC: CondEx = ~v;
            COND_HI: CondEx = c & ~z;
            COND_LS: CondEx = ~c | z;
            COND_GE: CondEx = (n == v);
            COND_LT: CondEx = (n != v);
            COND_GT: CondEx = ~z & (n == v);
            COND_LE: CondEx = z | (n != v);
            COND_AL: CondEx = 1'b1;
            default: CondEx = 1'b0;
        endcase
    end

    // NZ and CV are written independently; CV only for add/subtract results.
    always_ff @(posedge clk) begin
        if (reset) begin
            flags <= 4'b0000;
        end else if (FlagUpd && CondEx) begin
            if (FlagW[1]) flags[3:2] <= ALUFlags[3:2];
            if (FlagW[0]) flags[1:0] <= ALUFlags[1:0];
        end
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle control unit: main decode FSM, ALU decode and a request/done
// handshake with watchdog towards EXU_N variable-latency execution units.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int EXU_N      = 2,
    parameter int TMO_CYCLES = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      Instr,
    input  logic [3:0]       ALUFlags,
    input  logic [EXU_N-1:0] ExuDone,
    output logic [EXU_N-1:0] ExuReq,
    output logic [EXU_N-1:0] ExuWrite,
    output logic             PCWrite,
    output logic             MemWrite,
    output logic             RegWrite,
    output logic             IRWrite,
    output logic             AdrSrc,
    output logic [1:0]       RegSrc,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ResultSrc,
    output logic [1:0]       ImmSrc,
    output logic [2:0]       ALUControl,
    output logic             Busy,
    output logic             Fault
);

    localparam int CNT_W = $clog2(TMO_CYCLES + 1);

    state_t             state, state_nxt;
    logic [1:0]         op;
    logic [5:0]         funct;
    logic               is_mul, is_exu, exu_valid, is_addsub;
    logic [3:0]         exu_idx, idx_q;
    logic [EXU_N-1:0]   exu_sel;
    logic               exu_done;
    logic [CNT_W-1:0]   wd_cnt;
    logic               cond_ex;
    logic [1:0]         flag_w;
    logic               flag_upd;
    logic               unused_instr;

    assign op        = Instr[27:26];
    assign funct     = Instr[25:20];
    assign is_mul    = (op == OP_DP) && (Instr[7:4] == 4'b1001) && (funct[5:4] == 2'b00);
    assign is_exu    = is_mul || (op == OP_EXU);
    assign exu_idx   = is_mul ? 4'd0 : Instr[11:8];
    assign exu_valid = (int'(exu_idx) < EXU_N);
    assign is_addsub = (funct[4:1] == CMD_ADD) || (funct[4:1] == CMD_SUB);
    assign unused_instr = ^{Instr[19:12], Instr[3:0]};

    // The latched index, not the live Instr, steers request, done and write.
    assign exu_sel  = EXU_N'(1) << idx_q;
    assign exu_done = |(ExuDone & exu_sel);

    assign flag_w   = {funct[0], funct[0] & is_addsub};
    assign flag_upd = (state == S_EXECR) || (state == S_EXECI);

    mc_condunit u_cond (
        .clk      (clk),
        .reset    (reset),
        .Cond     (Instr[31:28]),
        .ALUFlags (ALUFlags),
        .FlagW    (flag_w),
        .FlagUpd  (flag_upd),
        .CondEx   (cond_ex)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_FETCH;
            wd_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_EXUSTART)
                wd_cnt <= '0;
            else if (state == S_EXUWAIT && !exu_done)
                wd_cnt <= wd_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (state == S_DECODE) idx_q <= exu_idx;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_FETCH:  state_nxt = S_DECODE;
            S_DECODE: begin
                if (is_exu)
                    state_nxt = (cond_ex && exu_valid) ? S_EXUSTART : S_FETCH;
                else if (op == OP_MEM)
                    state_nxt = S_MEMADR;
                else if (op == OP_BR)
                    state_nxt = S_BRANCH;
                else
                    state_nxt = funct[5] ? S_EXECI : S_EXECR;
            end
            S_MEMADR:   state_nxt = funct[0] ? S_MEMRD : S_MEMWR;
            S_MEMRD:    state_nxt = S_MEMWB;
            S_MEMWB:    state_nxt = S_FETCH;
            S_MEMWR:    state_nxt = S_FETCH;
            S_EXECR:    state_nxt = S_ALUWB;
            S_EXECI:    state_nxt = S_ALUWB;
            S_ALUWB:    state_nxt = S_FETCH;
            S_BRANCH:   state_nxt = S_FETCH;
            S_EXUSTART: state_nxt = S_EXUWAIT;
            S_EXUWAIT: begin
                if (exu_done)
                    state_nxt = S_EXUWB;
                else if (wd_cnt == CNT_W'(TMO_CYCLES - 1))
                    state_nxt = S_FAULT;
            end
            S_EXUWB:    state_nxt = S_FETCH;
            S_FAULT:    state_nxt = S_FAULT;
            default:    state_nxt = S_FETCH;
        endcase
    end

    // Outputs are forced low for the whole reset cycle.
    always_comb begin
        ExuReq     = '0;
        ExuWrite   = '0;
        PCWrite    = 1'b0;
        MemWrite   = 1'b0;
        RegWrite   = 1'b0;
        IRWrite    = 1'b0;
        AdrSrc     = 1'b0;
        RegSrc     = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ResultSrc  = 2'b00;
        ImmSrc     = 2'b00;
        ALUControl = ALU_ADD;
        Busy       = 1'b0;
        Fault      = 1'b0;
        if (!reset) begin
            if (state != S_FAULT) begin
                RegSrc = {op == OP_MEM, op == OP_BR};
                ImmSrc = op;
            end
            case (state)
                S_FETCH: begin
                    IRWrite   = 1'b1;
                    PCWrite   = 1'b1;
                    ALUSrcA   = SRCA_PC;
                    ALUSrcB   = SRCB_FOUR;
                    ResultSrc = RES_ALU;
                end
                S_DECODE: begin
                    ALUSrcA   = SRCA_PC;
                    ALUSrcB   = SRCB_FOUR;
                    ResultSrc = RES_ALU;
                end
                S_MEMADR: ALUSrcB = SRCB_IMM;
                S_MEMRD:  AdrSrc  = 1'b1;
                S_MEMWB: begin
                    ResultSrc = RES_RDATA;
                    RegWrite  = cond_ex;
                end
                S_MEMWR: begin
                    AdrSrc   = 1'b1;
                    MemWrite = cond_ex;
                end
                S_EXECR: begin
                    ALUSrcB    = SRCB_REG;
                    ALUControl = alu_decode(funct[4:1]);
                end
                S_EXECI: begin
                    ALUSrcB    = SRCB_IMM;
                    ALUControl = alu_decode(funct[4:1]);
                end
                S_ALUWB:  RegWrite = cond_ex && (funct[4:3] != 2'b10);
                S_BRANCH: begin
                    ALUSrcB   = SRCB_IMM;
                    ResultSrc = RES_ALU;
                    PCWrite   = cond_ex;
                end
                S_EXUSTART: begin
                    ExuReq = exu_sel;
                    Busy   = 1'b1;
                end
                S_EXUWAIT: Busy     = 1'b1;
                S_EXUWB:   ExuWrite = exu_sel;
                S_FAULT:   Fault    = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed vector table, hand-written corner
// sequences and random instruction streams against a per-instruction model.
module tb_multicycle_ctrl;

    localparam int EXU_N = 2;
    localparam int TMO   = 64;

    localparam int C_DPR = 0;
    localparam int C_DPI = 1;
    localparam int C_LD  = 2;
    localparam int C_ST  = 3;
    localparam int C_BR  = 4;
    localparam int C_EXU = 5;

    logic             clk = 1'b0;
    logic             reset;
    logic [31:0]      Instr;
    logic [3:0]       ALUFlags;
    logic [EXU_N-1:0] ExuDone;
    logic [EXU_N-1:0] ExuReq, ExuWrite;
    logic             PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc;
    logic [1:0]       RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc;
    logic [2:0]       ALUControl;
    logic             Busy, Fault;

    typedef struct packed {
        logic [1:0] req;
        logic [1:0] wr;
        logic       pcw;
        logic       memw;
        logic       regw;
        logic       irw;
        logic       adr;
        logic [1:0] regsrc;
        logic [1:0] srca;
        logic [1:0] srcb;
        logic [1:0] ressrc;
        logic [1:0] imm;
        logic [2:0] aluc;
        logic       busy;
        logic       fault;
    } outs_t;

    typedef struct packed {
        logic [31:0] ins;
        int          k;
        int          len;
        logic [3:0]  aluf;
        logic [1:0]  req;
        logic [1:0]  wr_last;
        logic        pcw_last;
        logic        regw_last;
        logic        memw_last;
    } vec_t;

    outs_t      act, last_act;
    logic [1:0] seen_req;
    int         req_cycles;
    logic [3:0] mflags;
    int         n_pass = 0;
    int         n_total = 0;
    vec_t       tbl [13];

    multicycle_ctrl #(.EXU_N(EXU_N), .TMO_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
        .ExuDone(ExuDone), .ExuReq(ExuReq), .ExuWrite(ExuWrite),
        .PCWrite(PCWrite), .MemWrite(MemWrite), .RegWrite(RegWrite),
        .IRWrite(IRWrite), .AdrSrc(AdrSrc), .RegSrc(RegSrc),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
        .ImmSrc(ImmSrc), .ALUControl(ALUControl), .Busy(Busy), .Fault(Fault)
    );

    always #5 clk = ~clk;

    always_comb act = {ExuReq, ExuWrite, PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc,
                       RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl, Busy, Fault};

    function automatic bit cond_ok(input logic [3:0] cc, input logic [3:0] f);
        bit b;
        case (cc[3:1])
            3'd0: b = f[2];
            3'd1: b = f[1];
            3'd2: b = f[3];
            3'd3: b = f[0];
            3'd4: b = f[1] && !f[2];
            3'd5: b = (f[3] == f[0]);
            3'd6: b = !f[2] && (f[3] == f[0]);
            default: b = 1'b1;
        endcase
        return b ^ cc[0];
    endfunction

    function automatic int iclass(input logic [31:0] ins);
        if (ins[27:26] == 2'd0 && ins[7:4] == 4'h9 && ins[25:24] == 2'd0) return C_EXU;
        case (ins[27:26])
            2'd0:    return ins[25] ? C_DPI : C_DPR;
            2'd1:    return ins[20] ? C_LD : C_ST;
            2'd2:    return C_BR;
            default: return C_EXU;
        endcase
    endfunction

    function automatic int unit_of(input logic [31:0] ins);
        return (ins[27:26] == 2'd3) ? int'(ins[11:8]) : 0;
    endfunction

    function automatic int instr_len(input logic [31:0] ins, input int k, input logic [3:0] f);
        case (iclass(ins))
            C_DPR, C_DPI, C_ST: return 4;
            C_LD:               return 5;
            C_BR:               return 3;
            default:            return (unit_of(ins) < EXU_N && cond_ok(ins[31:28], f)) ? 4 + k : 2;
        endcase
    endfunction

    function automatic logic [2:0] alu_of(input logic [3:0] cmd);
        case (cmd)
            4'b0100: return 3'd0;
            4'b0010: return 3'd1;
            4'b0000: return 3'd2;
            4'b1100: return 3'd3;
            default: return 3'd0;
        endcase
    endfunction

    // Expected outputs for cycle s of one instruction; k=0 means done never comes.
    function automatic outs_t model(input logic [31:0] ins, input logic [3:0] f,
                                    input int s, input int k);
        outs_t o;
        bit    ok;
        int    u;
        o        = '0;
        ok       = cond_ok(ins[31:28], f);
        u        = unit_of(ins);
        o.regsrc = {ins[27:26] == 2'd1, ins[27:26] == 2'd2};
        o.imm    = ins[27:26];
        if (s == 0) begin
            o.irw = 1'b1; o.pcw = 1'b1; o.srca = 2'd1; o.srcb = 2'd2; o.ressrc = 2'd2;
        end else if (s == 1) begin
            o.srca = 2'd1; o.srcb = 2'd2; o.ressrc = 2'd2;
        end else begin
            case (iclass(ins))
                C_DPR, C_DPI: begin
                    if (s == 2) begin
                        o.srcb = ins[25] ? 2'd1 : 2'd0;
                        o.aluc = alu_of(ins[24:21]);
                    end else begin
                        o.regw = ok && (ins[24:23] != 2'b10);
                    end
                end
                C_LD: begin
                    if (s == 2) o.srcb = 2'd1;
                    else if (s == 3) o.adr = 1'b1;
                    else begin o.ressrc = 2'd1; o.regw = ok; end
                end
                C_ST: begin
                    if (s == 2) o.srcb = 2'd1;
                    else begin o.adr = 1'b1; o.memw = ok; end
                end
                C_BR: begin
                    o.srcb = 2'd1; o.ressrc = 2'd2; o.pcw = ok;
                end
                default: begin
                    if (k == 0 && s >= 3 + TMO) begin
                        o = '0; o.fault = 1'b1;
                    end else if (s == 2) begin
                        o.req = EXU_N'(1) << u; o.busy = 1'b1;
                    end else if (k == 0 || s < 3 + k) begin
                        o.busy = 1'b1;
                    end else begin
                        o.wr = EXU_N'(1) << u;
                    end
                end
            endcase
        end
        return o;
    endfunction

    task automatic check_out(input string nm, input int s, input outs_t a, input outs_t e);
        n_total++;
        if (a !== e) $display("FAIL %s step %0d: got %h expected %h", nm, s, a, e);
        else n_pass++;
    endtask

    task automatic check_int(input string nm, input int a, input int e);
        n_total++;
        if (a != e) $display("FAIL %s: got %0d expected %0d", nm, a, e);
        else n_pass++;
    endtask

    task automatic run_instr(input string nm, input logic [31:0] ins, input int k,
                             input int n, input logic [3:0] aluf, input bit rnd);
        int    cls, u;
        outs_t e;
        cls = iclass(ins);
        u   = unit_of(ins);
        seen_req   = '0;
        req_cycles = 0;
        for (int s = 0; s < n; s++) begin
            Instr = ins;
            if (cls == C_EXU && s >= 3) begin
                Instr[31:28] = 4'($urandom);
                Instr[11:8]  = 4'($urandom);
            end
            ALUFlags = rnd ? 4'($urandom) : aluf;
            ExuDone  = EXU_N'($urandom);
            if (cls == C_EXU && s >= 3 && u < EXU_N) begin
                if (k == 0 && s >= 3 + TMO) ExuDone = '1;
                else ExuDone[u] = (k != 0) && (s == 2 + k);
            end
            #2;
            e = model(ins, mflags, s, k);
            check_out(nm, s, act, e);
            last_act = act;
            seen_req = seen_req | act.req;
            if (act.req != '0) req_cycles++;
            if ((cls == C_DPR || cls == C_DPI) && s == 2 && ins[20] && cond_ok(ins[31:28], mflags)) begin
                mflags[3:2] = ALUFlags[3:2];
                if (ins[24:21] == 4'b0100 || ins[24:21] == 4'b0010) mflags[1:0] = ALUFlags[1:0];
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic do_reset(input logic [EXU_N-1:0] done);
        reset   = 1'b1;
        ExuDone = done;
        Instr   = $urandom;
        #2;
        check_out("reset", 0, act, '0);
        @(posedge clk); #1;
        reset  = 1'b0;
        mflags = 4'b0000;
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        logic [31:0] ins;
        int          k;
        reset    = 1'b1;
        Instr    = '0;
        ALUFlags = '0;
        ExuDone  = '0;
        mflags   = '0;
        // {ins, k, len, aluf, req, wr_last, pcw_last, regw_last, memw_last}
        tbl[0]  = '{32'hE0910002, 0, 4, 4'b0100, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0};
        tbl[1]  = '{32'h0A000000, 0, 3, 4'b0000, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0};
        tbl[2]  = '{32'h1A000000, 0, 3, 4'b0000, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{32'hEC000100, 3, 7, 4'b0000, 2'b10, 2'b10, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{32'h1C000100, 0, 2, 4'b0000, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{32'hEC000300, 0, 2, 4'b0000, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{32'hE0000090, 1, 5, 4'b0000, 2'b01, 2'b01, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{32'hE5900000, 0, 5, 4'b0000, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0};
        tbl[8]  = '{32'hE5800000, 0, 4, 4'b0000, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1};
        tbl[9]  = '{32'hE1500000, 0, 4, 4'b0000, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{32'h0A000000, 0, 3, 4'b0000, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
        tbl[11] = '{32'h02800000, 0, 4, 4'b0000, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
        tbl[12] = '{32'hE3800000, 0, 4, 4'b0000, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0};

        @(posedge clk); #1;
        do_reset('0);

        for (int i = 0; i < 13; i++) begin
            run_instr($sformatf("vec%0d", i), tbl[i].ins, tbl[i].k, tbl[i].len, tbl[i].aluf, 1'b0);
            check_int($sformatf("vec%0d_req", i), int'(seen_req), int'(tbl[i].req));
            check_int($sformatf("vec%0d_req_once", i), req_cycles, (tbl[i].req != 2'b00) ? 1 : 0);
            check_int($sformatf("vec%0d_last", i),
                      int'({last_act.wr, last_act.pcw, last_act.regw, last_act.memw}),
                      int'({tbl[i].wr_last, tbl[i].pcw_last, tbl[i].regw_last, tbl[i].memw_last}));
        end

        // Watchdog: unit 1 never answers; fault must appear and stay.
        run_instr("timeout", 32'hEC000100, 0, 3 + TMO + 4, 4'b0000, 1'b1);
        check_int("fault_sticky", int'(Fault), 1);
        do_reset('1);
        run_instr("post_fault", 32'hE0910002, 0, 4, 4'b0000, 1'b0);

        // Reset mid-wait with done pending: no write-back afterwards.
        run_instr("midwait", 32'hE0000090, 10, 6, 4'b0000, 1'b1);
        do_reset('1);
        run_instr("after_abort", 32'hE3800000, 0, 4, 4'b0000, 1'b0);

        for (int i = 0; i < 80; i++) begin
            ins = $urandom;
            case ($urandom_range(0, 5))
                0, 5: begin
                    ins[27:26] = 2'd0;
                    ins[7]     = 1'b0;
                    case ($urandom_range(0, 4))
                        0: ins[24:21] = 4'b0100;
                        1: ins[24:21] = 4'b0010;
                        2: ins[24:21] = 4'b0000;
                        3: ins[24:21] = 4'b1100;
                        default: ins[24:21] = 4'b1010;
                    endcase
                end
                1: ins[27:26] = 2'd1;
                2: ins[27:26] = 2'd2;
                3: begin
                    ins[27:26] = 2'd3;
                    ins[11:8]  = 4'($urandom_range(0, 3));
                end
                default: begin
                    ins[27:24] = 4'd0;
                    ins[7:4]   = 4'h9;
                end
            endcase
            if ($urandom_range(0, 2) == 0) ins[31:28] = 4'hE;
            k = $urandom_range(1, 6);
            run_instr($sformatf("rnd%0d", i), ins, k, instr_len(ins, k, mflags), 4'b0000, 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
